// File: rtl/psum_ctrl.sv
// psum_ctrl: partial-sum scratchpad controller that loads psums, accumulates MAC products over passes, and drains them.
// Define PSUM_SAT_EN for saturating accumulation with a sticky ovf flag; otherwise sums wrap and ovf is 0.
module psum_ctrl #(
    parameter int MEM_DEPTH  = 24,
    parameter int DATA_WIDTH = 16,
    parameter int ADDR_WIDTH = $clog2(MEM_DEPTH)
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  start,
    input  logic [ADDR_WIDTH-1:0] cfg_len,
    input  logic [7:0]            cfg_passes,
    input  logic [DATA_WIDTH-1:0] psum_in_data,
    input  logic                  psum_in_valid,
    output logic                  psum_in_ready,
    input  logic [DATA_WIDTH-1:0] mac_data,
    input  logic                  mac_valid,
    output logic                  mac_ready,
    output logic [DATA_WIDTH-1:0] psum_out_data,
    output logic                  psum_out_valid,
    input  logic                  psum_out_ready,
    output logic                  spad_w_en,
    output logic [ADDR_WIDTH-1:0] spad_w_addr,
    output logic [DATA_WIDTH-1:0] spad_din,
    output logic [ADDR_WIDTH-1:0] spad_r_addr,
    input  logic [DATA_WIDTH-1:0] spad_dout,
    output logic                  busy,
    output logic                  done,
    output logic                  ovf
);

    typedef enum logic [1:0] {
        S_IDLE,
        S_LOAD,
        S_ACCUM,
        S_DRAIN
    } state_t;

    state_t                  state_q, state_d;
    logic [ADDR_WIDTH-1:0]   addr_q, addr_d;
    logic [ADDR_WIDTH-1:0]   len_q, len_d;
    logic [7:0]              pass_q, pass_d;
    logic [7:0]              passes_q, passes_d;
    logic                    last_addr;
    logic [DATA_WIDTH-1:0]   sum_raw;
    logic [DATA_WIDTH-1:0]   sum;

    assign last_addr     = (addr_q == len_q);
    assign spad_r_addr   = addr_q;
    assign psum_out_data = spad_dout;
    assign busy          = (state_q != S_IDLE);

    // Two's complement addition is sign-agnostic at equal widths; signedness only matters for overflow.
    assign sum_raw = spad_dout + mac_data;

`ifdef PSUM_SAT_EN
    localparam logic [DATA_WIDTH-1:0] SAT_MAX = {1'b0, {(DATA_WIDTH-1){1'b1}}};
    localparam logic [DATA_WIDTH-1:0] SAT_MIN = {1'b1, {(DATA_WIDTH-1){1'b0}}};

    logic sum_ovf;
    logic ovf_q, ovf_d;

    // Overflow only when both operands share a sign and the result sign differs.
    assign sum_ovf = (spad_dout[DATA_WIDTH-1] == mac_data[DATA_WIDTH-1]) &&
                     (sum_raw[DATA_WIDTH-1] != spad_dout[DATA_WIDTH-1]);
    assign sum     = sum_ovf ? (spad_dout[DATA_WIDTH-1] ? SAT_MIN : SAT_MAX) : sum_raw;

    always_comb begin
        ovf_d = ovf_q;
        if (state_q == S_IDLE && start) begin
            ovf_d = 1'b0;
        end else if (state_q == S_ACCUM && mac_valid && sum_ovf) begin
            ovf_d = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            ovf_q <= 1'b0;
        end else begin
            ovf_q <= ovf_d;
        end
    end

    assign ovf = ovf_q;
`else
    assign sum = sum_raw;
    assign ovf = 1'b0;
`endif

    always_comb begin
        // NOTE: every output and next-state value gets a default first so no path infers a latch.
        state_d        = state_q;
        addr_d         = addr_q;
        len_d          = len_q;
        pass_d         = pass_q;
        passes_d       = passes_q;
        psum_in_ready  = 1'b0;
        mac_ready      = 1'b0;
        psum_out_valid = 1'b0;
        done           = 1'b0;
        spad_w_en      = 1'b0;
        spad_w_addr    = addr_q;
        spad_din       = '0;

        case (state_q)
            S_IDLE: begin
                if (start) begin
                    len_d    = cfg_len;
                    passes_d = cfg_passes;
                    addr_d   = '0;
                    pass_d   = '0;
                    state_d  = S_LOAD;
                end
            end

            S_LOAD: begin
                psum_in_ready = 1'b1;
                if (psum_in_valid) begin
                    spad_w_en = 1'b1;
                    spad_din  = psum_in_data;
                    if (last_addr) begin
                        addr_d  = '0;
                        state_d = (passes_q == 8'd0) ? S_DRAIN : S_ACCUM;
                    end else begin
                        addr_d = addr_q + 1'b1;
                    end
                end
            end

            S_ACCUM: begin
                // Read at the falling edge sees the write of the preceding rising edge, so RMW never stalls.
                mac_ready = 1'b1;
                if (mac_valid) begin
                    spad_w_en = 1'b1;
                    spad_din  = sum;
                    if (last_addr) begin
                        addr_d = '0;
                        pass_d = pass_q + 8'd1;
                        if (pass_d == passes_q) begin
                            state_d = S_DRAIN;
                        end
                    end else begin
                        addr_d = addr_q + 1'b1;
                    end
                end
            end

            S_DRAIN: begin
                psum_out_valid = 1'b1;
                if (psum_out_ready) begin
                    if (last_addr) begin
                        done    = 1'b1;
                        addr_d  = '0;
                        state_d = S_IDLE;
                    end else begin
                        addr_d = addr_q + 1'b1;
                    end
                end
            end

            default: state_d = S_IDLE;
        endcase
    end

    // NOTE: the psum storage lives in the external scratchpad and is never reset; only control state is.
    always_ff @(posedge clk) begin
        // NOTE: non-blocking assignments keep every flop sampling pre-edge values.
        if (reset) begin
            state_q  <= S_IDLE;
            addr_q   <= '0;
            len_q    <= '0;
            pass_q   <= '0;
            passes_q <= '0;
        end else begin
            state_q  <= state_d;
            addr_q   <= addr_d;
            len_q    <= len_d;
            pass_q   <= pass_d;
            passes_q <= passes_d;
        end
    end

endmodule

// File: doc/psum_ctrl.md
PSUM_CTRL -- requirements
Module: psum_ctrl

Interface
REQ-001 SHALL have parameters: MEM_DEPTH, default 24, number of psum entries; DATA_WIDTH, default 16, psum width (signed two's complement); ADDR_WIDTH, default $clog2(MEM_DEPTH), spad address width.
REQ-002 SHALL have ports (clock and reset first):
- clk  in  1  single clock; all state updates on rising edge
- reset  in  1  synchronous active-high reset
- start  in  1  begin job; sampled only in IDLE
- cfg_len  in  ADDR_WIDTH  psum count minus 1 (0..MEM_DEPTH-1)
- cfg_passes  in  8  accumulation passes over all psums
- psum_in_data  in  DATA_WIDTH  initial psum
- psum_in_valid  in  1  initial psum valid
- psum_in_ready  out  1  initial psum accepted
- mac_data  in  DATA_WIDTH  MAC product to accumulate
- mac_valid  in  1  MAC product valid
- mac_ready  out  1  MAC product accepted
- psum_out_data  out  DATA_WIDTH  drained psum
- psum_out_valid  out  1  drained psum valid
- psum_out_ready  in  1  downstream accepts psum
- spad_w_en  out  1  psum scratchpad write enable
- spad_w_addr  out  ADDR_WIDTH  scratchpad write address
- spad_din  out  DATA_WIDTH  scratchpad write data
- spad_r_addr  out  ADDR_WIDTH  scratchpad read address
- spad_dout  in  DATA_WIDTH  scratchpad read data (valid within the same cycle; scratchpad reads on falling edge)
- busy  out  1  high in any state except IDLE
- done  out  1  one-cycle pulse on job completion
- ovf  out  1  sticky saturation flag

Function
REQ-003 SHALL implement states IDLE, LOAD, ACCUM, DRAIN; one address counter addr and one 8-bit pass counter.
REQ-004 IDLE: start=1 SHALL latch cfg_len/cfg_passes, clear addr, pass counter and ovf, and enter LOAD next cycle; start in any other state SHALL be ignored.
REQ-005 LOAD: psum_in_ready=1; each psum_in_valid&&psum_in_ready beat SHALL drive spad_w_en=1, spad_w_addr=addr, spad_din=psum_in_data and increment addr.
REQ-006 LOAD beat with addr==cfg_len SHALL clear addr and enter ACCUM, or DRAIN if cfg_passes==0.
REQ-007 ACCUM: mac_ready=1; each mac handshake SHALL drive spad_w_en=1, spad_w_addr=addr, spad_din=spad_dout+mac_data (read-modify-write in one cycle, throughput one per cycle).
REQ-008 ACCUM beat with addr==cfg_len SHALL wrap addr to 0 and increment pass counter; when the pass counter reaches cfg_passes, SHALL enter DRAIN.
REQ-009 Back-to-back RMW to the same address (cfg_len=0) SHALL accumulate correctly with no stall (write at rising edge precedes the falling-edge read).
REQ-010 spad_r_addr SHALL equal addr in every state.
REQ-011 DRAIN: psum_out_valid=1, psum_out_data=spad_dout; each handshake SHALL increment addr; handshake with addr==cfg_len SHALL pulse done for that cycle... and return to IDLE next cycle.
REQ-012 psum_out_data/psum_out_valid SHALL hold stable while psum_out_ready=0.
REQ-013 spad_w_en SHALL be 0 in IDLE, DRAIN, and on cycles without a handshake; ready outputs SHALL be 0 outside their state.
REQ-014 Addition width SHALL be DATA_WIDTH bits, both operands signed.

Reset
REQ-015 reset=1 at a rising edge SHALL force IDLE, addr=0, pass counter=0, ovf=0; outputs busy, done, psum_in_ready, mac_ready, psum_out_valid, spad_w_en =0.
REQ-016 Reset mid-job SHALL abort with no further spad writes; scratchpad contents SHALL NOT be cleared; reset dominates start.

Configuration
REQ-017 Macro PSUM_SAT_EN defined: ACCUM sum SHALL clamp to +2^(DATA_WIDTH-1)-1 / -2^(DATA_WIDTH-1) on signed overflow and set ovf sticky until next accepted start or reset.
REQ-018 PSUM_SAT_EN undefined: sum SHALL wrap modulo 2^DATA_WIDTH and ovf SHALL be constant 0.

Verification
REQ-019 cfg_len=3, cfg_passes=2, load {1,2,3,4}, MACs 10 each (8 beats) -> drain {21,22,23,24}, done one pulse, busy low next cycle.
REQ-020 cfg_len=0, cfg_passes=5, load 0, MACs {1..5} back-to-back -> drain 15, no stall cycles in ACCUM.
REQ-021 cfg_passes=0, cfg_len=1, load {7,-3} -> ACCUM skipped, mac_ready never high, drain {7,-3}.
REQ-022 Load 32767, MAC 1 -> with PSUM_SAT_EN drain 32767, ovf=1; without drain -32768, ovf=0.
REQ-023 psum_out_ready held low 4 cycles during DRAIN -> data/valid stable; reset asserted in ACCUM -> IDLE next cycle, spad_w_en=0, start during busy ignored.
